control_unit_gen2: RTL and testbench

CONTROL_UNIT_GEN2 -- requirements
Module: control_unit_gen2

---
 rtl/control_unit_gen2.sv | 187 ++++++++++++++++++
 tb/tb_control_unit_gen2.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_gen2.sv
// control_unit_gen2: multi-cycle controller for a small register machine.
// Sequences fetch/decode/memory/execute over an external memory and an
// external combinational ALU; holds PC, IR, the register file and N/Z/V flags.
module control_unit_gen2 #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4,
    parameter int unsigned RN = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic          alu_sub,
    input  logic [DW-1:0] alu_y,
    input  logic          alu_ovf,
    input  logic          alu_zero,
    input  logic          alu_neg,
    output logic [AW-1:0] pc,
    output logic          halted
);
    localparam int unsigned NR = 2 ** RN;

    localparam logic [3:0] OpHalt    = 4'b0000;
    localparam logic [3:0] OpLoadB   = 4'b0001;
    localparam logic [3:0] OpLoadA   = 4'b0010;
    localparam logic [3:0] OpStoreA  = 4'b0100;
    localparam logic [3:0] OpAdd     = 4'b1000;
    localparam logic [3:0] OpSub     = 4'b1001;
    localparam logic [3:0] OpJump    = 4'b1010;
    localparam logic [3:0] OpJumpNeg = 4'b1011;
    localparam logic [3:0] OpJumpZer = 4'b1100;
    localparam logic [3:0] OpJumpOvf = 4'b1101;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StMem,
        StExec,
        StHalt
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [DW-1:0] regs_q [NR];
    logic [DW-1:0] regs_d [NR];
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic          flag_n_q, flag_n_d;
    logic          flag_z_q, flag_z_d;
    logic          flag_v_q, flag_v_d;

    logic [3:0]    opcode;
    logic [AW-1:0] addr;
    logic [RN-1:0] ra;
    logic [RN-1:0] rb;
    logic          is_load;
    logic          is_store;

    assign opcode   = ir_q[DW-1:DW-4];
    assign addr     = ir_q[AW-1:0];
    assign ra       = ir_q[2*RN-1:RN];
    assign rb       = ir_q[RN-1:0];
    assign is_load  = (opcode == OpLoadA) || (opcode == OpLoadB);
    assign is_store = (opcode == OpStoreA);

    assign pc        = pc_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign mem_wdata = regs_q[0];
    assign halted    = (state_q == StHalt);
    assign alu_sub   = (state_q == StExec) && ir_q[DW-4];

    // State register, architectural registers and flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StFetch;
            pc_q     <= '0;
            ir_q     <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_v_q <= 1'b0;
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
            flag_v_q <= flag_v_d;
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Next-state and register-update decode
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        flag_v_d = flag_v_q;
        for (int i = 0; i < NR; i++) begin
            regs_d[i] = regs_q[i];
        end

        case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + AW'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StFetch;
                case (opcode)
                    OpHalt:    state_d = StHalt;
                    OpJump:    pc_d = addr;
                    OpJumpNeg: if (flag_n_q) pc_d = addr;
                    OpJumpZer: if (flag_z_q) pc_d = addr;
                    OpJumpOvf: if (flag_v_q) pc_d = addr;
                    OpLoadA, OpLoadB, OpStoreA: state_d = StMem;
                    OpAdd, OpSub: begin
                        alu_a_d = regs_q[ra];
                        alu_b_d = regs_q[rb];
                        state_d = StExec;
                    end
                    default: state_d = StFetch;
                endcase
            end
            StMem: begin
                if (mem_ready) begin
                    if (opcode == OpLoadA) regs_d[0] = mem_rdata;
                    if (opcode == OpLoadB) regs_d[1] = mem_rdata;
                    state_d = StFetch;
                end
            end
            StExec: begin
                regs_d[rb] = alu_y;
                flag_n_d   = alu_neg;
                flag_z_d   = alu_zero;
                flag_v_d   = alu_ovf;
                state_d    = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Memory bus decode; strobes are gated by reset so a pending transfer aborts at once
    always_comb begin
        mem_addr = pc_q;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        case (state_q)
            StFetch: mem_rd = 1'b1;
            StMem: begin
                mem_addr = addr;
                mem_rd   = is_load;
                mem_wr   = is_store;
            end
            default: ;
        endcase
        if (!rst) begin
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit_gen2.sv
// tb_control_unit_gen2: directed programs run on an 8-bit and a 16-bit instance,
// each with its own behavioural memory and ALU.
module tb_control_unit_gen2;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 8-bit instance (default parameters)
    logic        rst8, ready8, load8;
    logic [3:0]  addr8, pc8;
    logic        rd8, wr8, sub8, ovf8, zero8, neg8, halted8;
    logic [7:0]  wdata8, rdata8, a8, b8, y8;
    logic [7:0]  mem8 [16];
    logic [7:0]  img8 [16];

    // 16-bit instance
    logic        rst16, ready16, load16;
    logic [7:0]  addr16, pc16;
    logic        rd16, wr16, sub16, ovf16, zero16, neg16, halted16;
    logic [15:0] wdata16, rdata16, a16, b16, y16;
    logic [15:0] mem16 [256];
    logic [15:0] img16 [256];

    control_unit_gen2 u8 (
        .clk(clk), .rst(rst8),
        .mem_addr(addr8), .mem_rd(rd8), .mem_wr(wr8), .mem_wdata(wdata8),
        .mem_rdata(rdata8), .mem_ready(ready8),
        .alu_a(a8), .alu_b(b8), .alu_sub(sub8), .alu_y(y8),
        .alu_ovf(ovf8), .alu_zero(zero8), .alu_neg(neg8),
        .pc(pc8), .halted(halted8)
    );

    control_unit_gen2 #(.DW(16), .AW(8), .RN(3)) u16 (
        .clk(clk), .rst(rst16),
        .mem_addr(addr16), .mem_rd(rd16), .mem_wr(wr16), .mem_wdata(wdata16),
        .mem_rdata(rdata16), .mem_ready(ready16),
        .alu_a(a16), .alu_b(b16), .alu_sub(sub16), .alu_y(y16),
        .alu_ovf(ovf16), .alu_zero(zero16), .alu_neg(neg16),
        .pc(pc16), .halted(halted16)
    );

    // Reference ALUs: y = a op b with two's-complement overflow
    assign y8    = sub8 ? a8 - b8 : a8 + b8;
    assign ovf8  = sub8 ? ((a8[7] != b8[7]) && (y8[7] != a8[7]))
                        : ((a8[7] == b8[7]) && (y8[7] != a8[7]));
    assign zero8 = (y8 == 8'h00);
    assign neg8  = y8[7];

    assign y16    = sub16 ? a16 - b16 : a16 + b16;
    assign ovf16  = sub16 ? ((a16[15] != b16[15]) && (y16[15] != a16[15]))
                          : ((a16[15] == b16[15]) && (y16[15] != a16[15]));
    assign zero16 = (y16 == 16'h0000);
    assign neg16  = y16[15];

    assign rdata8  = mem8[addr8];
    assign rdata16 = mem16[addr16];

    // 8-bit memory: image load or completed write
    always @(posedge clk) begin
        if (load8) begin
            for (int i = 0; i < 16; i++) mem8[i] <= img8[i];
        end else if (wr8 && ready8) begin
            mem8[addr8] <= wdata8;
        end
    end

    // 16-bit memory: image load or completed write
    always @(posedge clk) begin
        if (load16) begin
            for (int i = 0; i < 256; i++) mem16[i] <= img16[i];
        end else if (wr16 && ready16) begin
            mem16[addr16] <= wdata16;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear8();
        for (int i = 0; i < 16; i++) img8[i] = 8'h00;
    endtask

    // Reset across one edge while the image loads; the next edge is the first fetch
    task automatic restart8();
        rst8   = 1'b0;
        ready8 = 1'b1;
        load8  = 1'b1;
        tick(1);
        load8 = 1'b0;
        rst8  = 1'b1;
    endtask

    task automatic restart16();
        rst16   = 1'b0;
        ready16 = 1'b1;
        load16  = 1'b1;
        tick(1);
        load16 = 1'b0;
        rst16  = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst8 = 1'b1; rst16 = 1'b1;
        ready8 = 1'b1; ready16 = 1'b1;
        load8 = 1'b0; load16 = 1'b0;
        clear8();
        for (int i = 0; i < 256; i++) img16[i] = 16'h0000;
        #1;
        rst8 = 1'b0; rst16 = 1'b0;
        #1;
        // Reset state
        check("rst_pc", pc8, 0);
        check("rst_rd", rd8, 0);
        check("rst_wr", wr8, 0);
        check("rst_halted", halted8, 0);
        check("rst_alu_a", a8, 0);
        check("rst_alu_b", b8, 0);

        // Program: LOAD_A 8; LOAD_B 9; ADD R0,R1; STORE_A 10; HALT
        clear8();
        img8[0] = 8'h28; img8[1] = 8'h19; img8[2] = 8'h81; img8[3] = 8'h4A; img8[4] = 8'h00;
        img8[8] = 8'h03; img8[9] = 8'h04; img8[10] = 8'hEE;
        restart8();
        tick(8);
        check("prog_alu_a", a8, 8'h03);
        check("prog_alu_b", b8, 8'h04);
        check("prog_alu_sub", sub8, 0);
        tick(3);
        check("prog_st_wr", wr8, 1);
        check("prog_st_rd", rd8, 0);
        check("prog_st_addr", addr8, 10);
        check("prog_st_wdata", wdata8, 8'h03);
        tick(1);
        check("prog_mem10", mem8[10], 8'h03);
        tick(2);
        check("prog_halted", halted8, 1);
        check("prog_pc", pc8, 5);
        check("prog_r1", u8.regs_q[1], 8'h07);
        tick(2);
        check("halt_pc_frozen", pc8, 5);
        check("halt_no_rd", rd8, 0);
        check("halt_stays", halted8, 1);

        // SUB R0,R1; LOAD_A 9; JUMP_NEG 7 -- positive result, branch not taken
        clear8();
        img8[0] = 8'h28; img8[1] = 8'h19; img8[2] = 8'h91; img8[3] = 8'h29; img8[4] = 8'hB7;
        img8[8] = 8'h05; img8[9] = 8'h02;
        restart8();
        tick(8);
        check("sub1_alu_a", a8, 8'h05);
        check("sub1_alu_b", b8, 8'h02);
        check("sub1_alu_sub", sub8, 1);
        tick(1);
        check("sub1_r1", u8.regs_q[1], 8'h03);
        tick(3);
        check("sub1_r0", u8.regs_q[0], 8'h02);
        tick(2);
        check("sub1_pc_seq", pc8, 5);
        tick(2);
        check("sub1_halted", halted8, 1);

        // Same program, negative result: N survives the LOAD and the branch is taken
        img8[8] = 8'h02; img8[9] = 8'h05;
        restart8();
        tick(8);
        check("sub2_alu_a", a8, 8'h02);
        check("sub2_alu_b", b8, 8'h05);
        tick(1);
        check("sub2_r1", u8.regs_q[1], 8'hFD);
        tick(3);
        check("sub2_n_after_load", u8.flag_n_q, 1);
        tick(2);
        check("sub2_pc_taken", pc8, 7);
        tick(2);
        check("sub2_halted", halted8, 1);

        // LOAD_A with mem_ready low for three cycles in MEM
        clear8();
        img8[0] = 8'h28; img8[8] = 8'h3C;
        restart8();
        tick(2);
        ready8 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_rd", rd8, 1);
            check("stall_addr", addr8, 8);
            check("stall_r0", u8.regs_q[0], 0);
            tick(1);
        end
        check("stall_end_addr", addr8, 8);
        ready8 = 1'b1;
        tick(1);
        check("stall_r0_loaded", u8.regs_q[0], 8'h3C);
        check("stall_next_fetch", addr8, 1);
        check("stall_next_rd", rd8, 1);

        // JUMP 14; at 14 JUMP 15; at 15 NOP -> PC wraps to 0
        clear8();
        img8[0] = 8'hAE; img8[14] = 8'hAF; img8[15] = 8'h70;
        restart8();
        tick(2);
        check("jmp_pc14", pc8, 14);
        tick(2);
        check("jmp_pc15", pc8, 15);
        tick(1);
        check("wrap_pc0", pc8, 0);
        tick(1);
        check("wrap_fetch_addr", addr8, 0);
        check("wrap_fetch_rd", rd8, 1);

        // Reset asserted while STORE_A is in MEM
        clear8();
        img8[0] = 8'h28; img8[1] = 8'h4A; img8[8] = 8'h5A; img8[10] = 8'h11;
        restart8();
        tick(5);
        check("abort_wr_before", wr8, 1);
        check("abort_addr_before", addr8, 10);
        check("abort_wdata_before", wdata8, 8'h5A);
        rst8 = 1'b0;
        #1;
        check("abort_wr_drop", wr8, 0);
        check("abort_rd_drop", rd8, 0);
        check("abort_pc0", pc8, 0);
        tick(1);
        check("abort_mem_kept", mem8[10], 8'h11);
        check("abort_r0_clear", u8.regs_q[0], 0);
        tick(1);
        rst8 = 1'b1;
        #1;
        check("abort_refetch_addr", addr8, 0);
        check("abort_refetch_rd", rd8, 1);
        tick(1);
        check("abort_refetch_pc", pc16 === pc16 ? pc8 : pc8, 1);
        check("abort_decode_rd", rd8, 0);

        // 16-bit instance: ADD R5,R6 overflows, JUMP_OVF 0x40 taken
        img16[0] = 16'h2020; img16[1] = 16'h8005; img16[2] = 16'h1021;
        img16[3] = 16'h800E; img16[4] = 16'h802E; img16[5] = 16'hD040;
        img16[8'h20] = 16'h7FFF; img16[8'h21] = 16'h0001; img16[8'h40] = 16'h0000;
        restart16();
        tick(14);
        check("w16_alu_a", a16, 16'h7FFF);
        check("w16_alu_b", b16, 16'h0001);
        check("w16_alu_sub", sub16, 0);
        tick(1);
        check("w16_r6", u16.regs_q[6], 16'h8000);
        check("w16_v", u16.flag_v_q, 1);
        check("w16_n", u16.flag_n_q, 1);
        check("w16_z", u16.flag_z_q, 0);
        tick(2);
        check("w16_pc_ovf_jump", pc16, 8'h40);
        tick(2);
        check("w16_halted", halted16, 1);
        check("w16_no_rd", rd16, 0);
        check("w16_no_wr", wr16, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
